// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// Imported by the arbiter top, its round-robin picker and the bench.
package mul_arb_pkg;

    localparam int MUL_W    = 32;
    localparam int MUL_LAT  = 5;
    localparam int MAX_NREQ = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request strictly after ptr_i
// wins, so the port at ptr_i itself is considered last.
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int c;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        // Walk from the farthest candidate to the nearest so the nearest hit is written last.
        for (int k = NREQ; k >= 1; k--) begin
            c = (int'(ptr_i) + k) % NREQ;
            if (req_i[c]) begin
                gnt_o    = '0;
                gnt_o[c] = 1'b1;
                idx_o    = IDX_W'(c);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// Shares one multi-cycle multiplier between NREQ requesters: per-port pending
// slots, round-robin grant, optional zero-operand bypass, one-hot completion.
module mul_share_arb
    import mul_arb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_i,
    input  logic [MUL_W*NREQ-1:0] p0_i,
    input  logic [MUL_W*NREQ-1:0] p1_i,
    output logic [NREQ-1:0]       ack_o,
    output logic [MUL_W-1:0]      res_o,
    output logic [NREQ-1:0]       err_o,
    output logic                  busy_o,
    output logic                  m_req,
    output logic [MUL_W-1:0]      m_p0,
    output logic [MUL_W-1:0]      m_p1,
    input  logic                  m_ack,
    input  logic [MUL_W-1:0]      m_out
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e             state_q, state_d;
    logic [NREQ-1:0]    pend_q, pend_d;
    logic [NREQ-1:0]    err_q, err_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic [MUL_W-1:0]   res_q, res_d;
    logic               m_req_q, m_req_d;
    logic [MUL_W-1:0]   m_p0_q, m_p0_d;
    logic [MUL_W-1:0]   m_p1_q, m_p1_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [MUL_W-1:0]   slot_p0_q [NREQ];
    logic [MUL_W-1:0]   slot_p0_d [NREQ];
    logic [MUL_W-1:0]   slot_p1_q [NREQ];
    logic [MUL_W-1:0]   slot_p1_d [NREQ];

    logic [NREQ-1:0]    win_mask;
    logic [NREQ-1:0]    pick_req;
    logic [NREQ-1:0]    pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    assign win_mask = NREQ'(1) << win_q;
    // While waiting, the in-flight port still has pend set but must not be re-granted.
    assign pick_req = (state_q == S_WAIT) ? (pend_q & ~win_mask) : pend_q;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i (pick_req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        pend_d    = pend_q;
        err_d     = err_q;
        ack_d     = '0;
        res_d     = res_q;
        m_req_d   = 1'b0;
        m_p0_d    = m_p0_q;
        m_p1_d    = m_p1_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        slot_p0_d = slot_p0_q;
        slot_p1_d = slot_p1_q;

        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    ptr_d = pick_idx;
                    win_d = pick_idx;
                    if (ZERO_BYPASS && ((slot_p0_q[pick_idx] == '0) || (slot_p1_q[pick_idx] == '0))) begin
                        res_d  = '0;
                        ack_d  = pick_gnt;
                        pend_d = pend_d & ~pick_gnt;
                    end else begin
                        m_req_d = 1'b1;
                        m_p0_d  = slot_p0_q[pick_idx];
                        m_p1_d  = slot_p1_q[pick_idx];
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (m_ack) begin
                    res_d  = m_out;
                    ack_d  = win_mask;
                    pend_d = pend_d & ~win_mask;
                    if (pick_any) begin
                        ptr_d   = pick_idx;
                        win_d   = pick_idx;
                        m_req_d = 1'b1;
                        m_p0_d  = slot_p0_q[pick_idx];
                        m_p1_d  = slot_p1_q[pick_idx];
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Accept uses the registered pend, so a slot freed this edge reopens next cycle.
        for (int i = 0; i < NREQ; i++) begin
            if (req_i[i]) begin
                if (pend_q[i]) begin
                    err_d[i] = 1'b1;
                end else begin
                    pend_d[i]    = 1'b1;
                    slot_p0_d[i] = p0_i[MUL_W*i +: MUL_W];
                    slot_p1_d[i] = p1_i[MUL_W*i +: MUL_W];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            err_q   <= '0;
            ack_q   <= '0;
            res_q   <= '0;
            m_req_q <= 1'b0;
            m_p0_q  <= '0;
            m_p1_q  <= '0;
            ptr_q   <= IDX_W'(NREQ - 1);
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            res_q   <= res_d;
            m_req_q <= m_req_d;
            m_p0_q  <= m_p0_d;
            m_p1_q  <= m_p1_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
        end
    end

    // NOTE: operand slots are storage qualified by pend, so they carry no reset.
    always_ff @(posedge clk) begin
        slot_p0_q <= slot_p0_d;
        slot_p1_q <= slot_p1_d;
    end

    assign ack_o  = ack_q;
    assign res_o  = res_q;
    assign err_o  = err_q;
    assign m_req  = m_req_q;
    assign m_p0   = m_p0_q;
    assign m_p1   = m_p1_q;
    assign busy_o = (|pend_q) || (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb: one DUT with zero bypass, one without,
// each driving its own behavioural multiplier (m_ack four cycles after m_req).
module tb_mul_share_arb;
    import mul_arb_pkg::*;

    localparam int NREQ = 2;

    logic                 clk   = 1'b0;
    logic                 rst   = 1'b1;
    logic [NREQ-1:0]      req_i = '0;
    logic [32*NREQ-1:0]   p0_i  = '0;
    logic [32*NREQ-1:0]   p1_i  = '0;

    logic [NREQ-1:0]      ack_a, err_a, ack_b, err_b;
    logic [31:0]          res_a, res_b;
    logic                 busy_a, busy_b;
    logic                 mreq_a, mreq_b;
    logic [31:0]          mp0_a, mp1_a, mp0_b, mp1_b;
    logic                 mack_a = 1'b0, mack_b = 1'b0;
    logic [31:0]          mout_a = '0, mout_b = '0;
    logic [2:0]           mcnt_a = '0, mcnt_b = '0;

    int cyc = 0, t0 = 0;
    int n_checks = 0, n_fail = 0;
    int mreq_a_cnt = 0, mreq_a_rel = -1, mreq_b_cnt = 0, ack_a_cnt = 0;

    mul_share_arb #(.NREQ(NREQ), .ZERO_BYPASS(1'b1)) u_dut (
        .clk(clk), .rst(rst), .req_i(req_i), .p0_i(p0_i), .p1_i(p1_i),
        .ack_o(ack_a), .res_o(res_a), .err_o(err_a), .busy_o(busy_a),
        .m_req(mreq_a), .m_p0(mp0_a), .m_p1(mp1_a), .m_ack(mack_a), .m_out(mout_a)
    );

    mul_share_arb #(.NREQ(NREQ), .ZERO_BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .req_i(req_i), .p0_i(p0_i), .p1_i(p1_i),
        .ack_o(ack_b), .res_o(res_b), .err_o(err_b), .busy_o(busy_b),
        .m_req(mreq_b), .m_p0(mp0_b), .m_p1(mp1_b), .m_ack(mack_b), .m_out(mout_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multipliers have no reset; a new m_req restarts the sequence.
    always @(posedge clk) begin
        mack_a <= 1'b0;
        if (mreq_a) begin
            mcnt_a <= 3'd3;
            mout_a <= mp0_a * mp1_a;
        end else if (mcnt_a != 3'd0) begin
            mcnt_a <= mcnt_a - 3'd1;
            if (mcnt_a == 3'd1) mack_a <= 1'b1;
        end
    end

    always @(posedge clk) begin
        mack_b <= 1'b0;
        if (mreq_b) begin
            mcnt_b <= 3'd3;
            mout_b <= mp0_b * mp1_b;
        end else if (mcnt_b != 3'd0) begin
            mcnt_b <= mcnt_b - 3'd1;
            if (mcnt_b == 3'd1) mack_b <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mreq_a) begin
            mreq_a_cnt <= mreq_a_cnt + 1;
            mreq_a_rel <= cyc - t0;
        end
        if (mreq_b) mreq_b_cnt <= mreq_b_cnt + 1;
        if (ack_a != '0) ack_a_cnt <= ack_a_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle request; the drive cycle becomes cycle 0 (t0).
    task automatic send(input logic [1:0] mask, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1);
        req_i = mask;
        p0_i  = {a1, a0};
        p1_i  = {b1, b0};
        t0    = cyc;
        tick();
        req_i = '0;
    endtask

    task automatic wait_ack(input bit use_b, input int max, output int rel);
        while (((use_b ? ack_b : ack_a) == '0) && ((cyc - t0) < max)) tick();
        rel = cyc - t0;
    endtask

    initial begin
        int rel;
        int base;
        int base_b;

        rst = 1'b1;
        repeat (3) tick();
        check("rst_ack", ack_a, 0);
        check("rst_res", res_a, 0);
        check("rst_err", err_a, 0);
        check("rst_mreq", mreq_a, 0);
        check("rst_busy", {busy_a, busy_b}, 0);
        rst = 1'b0;
        tick();

        // Contention: pointer starts at NREQ-1, so port 0 wins first.
        base = mreq_a_cnt;
        send(2'b11, 32'd7, 32'd6, 32'd9, 32'd9);
        check("ctA_busy", busy_a, 1);
        wait_ack(0, 20, rel);
        check("ctA_first_cyc", rel, 7);
        check("ctA_first_ack", ack_a, 2'b01);
        check("ctA_first_res", res_a, 42);
        check("ctA_mreq_in_ack", mreq_a, 1);
        tick();
        wait_ack(0, 30, rel);
        check("ctA_second_cyc", rel, 7 + MUL_LAT);
        check("ctA_second_ack", ack_a, 2'b10);
        check("ctA_second_res", res_a, 81);
        check("ctA_mreq_count", mreq_a_cnt - base, 2);

        // Single op, then a re-request on the ack cycle.
        send(2'b01, 32'd3, 32'd5, 32'd0, 32'd0);
        tick();
        check("single_mreq_c2", mreq_a, 1);
        check("single_operands", {mp0_a, mp1_a}, {32'd3, 32'd5});
        wait_ack(0, 20, rel);
        check("single_cyc", rel, 7);
        check("single_ack", ack_a, 2'b01);
        check("single_res", res_a, 32'h0000000F);
        req_i = 2'b01;
        p0_i  = {32'd0, 32'd2};
        p1_i  = {32'd0, 32'd8};
        t0    = cyc;
        tick();
        req_i = '0;
        check("reack_no_err", err_a, 0);
        wait_ack(0, 20, rel);
        check("reack_cyc", rel, 7);
        check("reack_res", res_a, 16);
        tick();
        check("hold_ack_low", ack_a, 0);
        check("hold_res", res_a, 16);
        check("hold_idle", busy_a, 0);

        // Same contention after port 0 last won: port 1 goes first.
        send(2'b11, 32'd7, 32'd6, 32'd9, 32'd9);
        wait_ack(0, 20, rel);
        check("ctB_first_cyc", rel, 7);
        check("ctB_first_ack", ack_a, 2'b10);
        check("ctB_first_res", res_a, 81);
        tick();
        wait_ack(0, 30, rel);
        check("ctB_second_cyc", rel, 12);
        check("ctB_second_ack", ack_a, 2'b01);
        check("ctB_second_res", res_a, 42);

        // Width wrap.
        base = mreq_a_cnt;
        send(2'b01, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0);
        wait_ack(0, 20, rel);
        check("wrap16_cyc", rel, 7);
        check("wrap16_res", res_a, 0);
        check("wrap16_mreq", mreq_a_cnt - base, 1);
        send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        wait_ack(0, 20, rel);
        check("wrapff_res", res_a, 32'h0000_0001);

        // Overrun: second request at cycle 3 is dropped.
        send(2'b01, 32'd4, 32'd5, 32'd0, 32'd0);
        base = ack_a_cnt;
        tick();
        tick();
        req_i = 2'b01;
        p0_i  = {32'd0, 32'd9};
        p1_i  = {32'd0, 32'd9};
        tick();
        req_i = '0;
        check("ovr_err", {err_a, err_b}, {2'b01, 2'b01});
        wait_ack(0, 20, rel);
        check("ovr_cyc", rel, 7);
        check("ovr_res", res_a, 20);
        repeat (8) tick();
        check("ovr_one_ack", ack_a_cnt - base, 1);
        check("ovr_err_sticky", err_a, 2'b01);

        // Async reset in cycle 4 of an op, then the stale m_ack must be ignored.
        send(2'b10, 32'd0, 32'd0, 32'd6, 32'd7);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("arst_res", res_a, 0);
        check("arst_err", err_a, 0);
        check("arst_mops", {mp0_a, mp1_a}, 0);
        check("arst_busy_mreq_ack", {busy_a, mreq_a, ack_a}, 0);
        tick();
        rst  = 1'b0;
        base = ack_a_cnt;
        repeat (6) tick();
        check("stale_mack_ignored", ack_a_cnt - base, 0);
        check("stale_idle", busy_a, 0);
        send(2'b01, 32'd2, 32'd2, 32'd0, 32'd0);
        wait_ack(0, 20, rel);
        check("post_rst_cyc", rel, 7);
        check("post_rst_res", res_a, 4);

        // Zero bypass versus a full multiply on the non-bypass instance.
        base   = mreq_a_cnt;
        base_b = mreq_b_cnt;
        send(2'b10, 32'd0, 32'd0, 32'd0, 32'h1234_5678);
        wait_ack(0, 20, rel);
        check("byp_cyc", rel, 2);
        check("byp_ack", ack_a, 2'b10);
        check("byp_res", res_a, 0);
        wait_ack(1, 20, rel);
        check("nobyp_cyc", rel, 7);
        check("nobyp_ack", ack_b, 2'b10);
        check("nobyp_res", res_b, 0);
        tick();
        check("byp_no_mreq", mreq_a_cnt - base, 0);
        check("nobyp_mreq", mreq_b_cnt - base_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one `mul32x32_fsm` multiplier between NREQ requesters, such as core execute ports and a DSP helper.
- Latches each requester's operands into a per-port pending slot and grants ports round-robin.
- Drives the multiplier's one-cycle `req` pulse and waits for its one-cycle `ack` pulse.
- Returns the low 32 bits of the product to the owning port with a one-cycle `ack_o` pulse.

Parameters:
- NREQ, 2, number of requester ports (2..4).
- ZERO_BYPASS, 1, when 1 a granted op with a zero operand completes without using the multiplier.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  NREQ  per-port one-cycle request strobe.
- p0_i  in  32*NREQ  per-port operand A; port i occupies bits [32i+31:32i].
- p1_i  in  32*NREQ  per-port operand B; same packing as p0_i.
- ack_o  out  NREQ  one-hot completion pulse.
- res_o  out  32  result; valid while any ack_o bit is 1, holds its value otherwise.
- err_o  out  NREQ  sticky per-port overrun flag.
- busy_o  out  1  high when any slot is pending or an op is in flight.
- m_req  out  1  multiplier start pulse.
- m_p0  out  32  multiplier operand A.
- m_p1  out  32  multiplier operand B.
- m_ack  in  1  multiplier done pulse.
- m_out  in  32  multiplier result.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; pend, ack_o, err_o, m_req = 0.
  - res_o, m_p0, m_p1 = 0; rr pointer = NREQ-1, so port 0 wins first.
  - The multiplier has no reset. m_ack is ignored in every state except WAIT.
  - Stale multiplier sequences are aborted by the next m_req, because the multiplier's req has priority over its stage logic.
- Request accept:
  - On a clk edge with req_i[i]=1 and pend[i]=0: store p0/p1 into slot i and set pend[i].
  - If pend[i]=1 (slot occupied or in flight), drop the request and set err_o[i]; it stays set until rst.
- Slot release: pend[i] clears on the edge on which port i's result is registered. A req_i[i] in the following ack_o cycle is accepted.
- Grant: round-robin over pend. The first set bit after the rr pointer wins; the pointer is updated to the winner on grant.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any pend bit is set, grant. If ZERO_BYPASS and a winner operand is 0, register res_o=0 and pulse ack_o[w] next cycle; stay IDLE. Otherwise go to ISSUE.
  - ISSUE: m_req=1 for exactly one cycle, with m_p0/m_p1 = winner slot; go to WAIT.
  - WAIT: hold m_p0/m_p1. On m_ack=1, register res_o=m_out and pulse ack_o[w] next cycle.
    - If another pend bit is set (excluding w), grant immediately and go to ISSUE; the next m_req coincides with ack_o.
    - Otherwise go to IDLE.
- Latency, req_i at cycle 0 into an idle arbiter:
  - Grant evaluated in cycle 1 (IDLE); m_req high in cycle 2.
  - Multiplier stages run in cycles 3-5; m_ack in cycle 6.
  - ack_o/res_o in cycle 7.
  - Zero bypass: ack_o in cycle 2.
- Throughput: one multiply every 5 cycles under contention.
- Simultaneous events:
  - At most one ack_o bit per cycle.
  - A new req on a non-pending port in the same cycle as a grant is stored and joins the next arbitration.
  - req_i for several ports in one cycle is all accepted.
- Arithmetic: result = (p0*p1) mod 2^32, unsigned, taken directly from the multiplier.
- busy_o = |pend or state != IDLE.

Decomposition:
- Package `mul_arb_pkg`:
  - State encoding (IDLE/ISSUE/WAIT, 2 bits).
  - MUL_W=32 and MUL_LAT=5 constants (ISSUE to m_ack, used by the bench checker).
  - Maximum NREQ.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: NREQ request vector, pointer.
  - Outputs: one-hot grant and winner index.

Test Plan:
- Single op: port0 3 x 5 -> m_req cycle 2; ack_o=01 and res_o=15 (0x0000000F) at cycle 7.
- Width wrap: 0x00010000 x 0x00010000 -> res_o=0 via multiplier (m_req seen). 0xFFFFFFFF x 0xFFFFFFFF -> res_o=0x00000001.
- Contention: port0 7x6 and port1 9x9 in the same cycle -> ack_o=01/res=42 first. ack_o=10/res=81 exactly 5 cycles later, with port1's m_req in port0's ack cycle. Repeat -> port1 now wins first.
- Overrun: port0 req at cycle 0 and again at cycle 3 -> second dropped; err_o[0]=1 sticky; only one ack_o, with the first operands.
- Reset mid-op: rst pulsed in cycle 4 of an op -> all outputs 0 asynchronously. Stale m_ack ignored (no ack_o). A new op 2x2 after reset -> res_o=4.
- Zero bypass: port1 0 x 0x12345678 -> no m_req; ack_o=10, res_o=0 at cycle 2. With ZERO_BYPASS=0 -> m_req issued, ack at cycle 7.
